// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as an 11-bit frame
// (start, 8 data bits LSB first, parity, stop) with every output driven from a flop.
module uart_tx #(
   parameter int BAUD_CNT    = 868,
   parameter bit PARITY_TYPE = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int             CW   = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(BAUD_CNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          wrap;
   logic          accept;

   assign wrap   = (baud_q == LAST);
   assign accept = tx_valid && ready_q;

   // Outputs are derived from the next state so that they are registered yet line
   // up exactly with the state they describe; txd falls in the cycle after accept.
   always_comb begin
      state_d = state_q;
      baud_d  = wrap ? '0 : baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (accept) begin
               state_d = START;
               shift_d = tx_data;
               par_d   = PARITY_TYPE ? ~^tx_data : ^tx_data;
            end
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            if (wrap) begin
               if (bit_q == 3'd7) begin
                  state_d = PARITY;
                  bit_d   = 3'd0;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (wrap) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase

      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_d;
         default: txd_d = 1'b1;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == STOP) && (baud_d == LAST);
   end

   // Single state register; reset abandons any frame and forces the line high at once.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd      = txd_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one full-rate instance plus two fast-baud
// instances (odd and even parity), compared against an arithmetic frame model.
module tb_uart_tx;

   localparam int NDUT = 3;
   localparam int FAST = 12;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] dataIn   [NDUT];
   logic       validIn  [NDUT];
   logic       readyOut [NDUT];
   logic       txdOut   [NDUT];
   logic       busyOut  [NDUT];
   logic       doneOut  [NDUT];

   int baudOf [NDUT] = '{868, FAST, FAST};
   bit oddOf  [NDUT] = '{1'b1, 1'b1, 1'b0};

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   uart_tx dutSlow (
      .sys_clk(clk), .sys_rst_n(rstN), .tx_data(dataIn[0]), .tx_valid(validIn[0]),
      .tx_ready(readyOut[0]), .txd(txdOut[0]), .tx_busy(busyOut[0]), .tx_done(doneOut[0])
   );

   uart_tx #(.BAUD_CNT(FAST), .PARITY_TYPE(1'b1)) dutOdd (
      .sys_clk(clk), .sys_rst_n(rstN), .tx_data(dataIn[1]), .tx_valid(validIn[1]),
      .tx_ready(readyOut[1]), .txd(txdOut[1]), .tx_busy(busyOut[1]), .tx_done(doneOut[1])
   );

   uart_tx #(.BAUD_CNT(FAST), .PARITY_TYPE(1'b0)) dutEven (
      .sys_clk(clk), .sys_rst_n(rstN), .tx_data(dataIn[2]), .tx_valid(validIn[2]),
      .tx_ready(readyOut[2]), .txd(txdOut[2]), .tx_busy(busyOut[2]), .tx_done(doneOut[2])
   );

   // Expected line level for bit k of the frame is element k of the returned vector.
   function automatic logic [10:0] frameBits(input logic [7:0] b, input bit odd);
      int   ones;
      logic parity;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      parity = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return {1'b1, parity, b, 1'b0};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input int idx, input logic [7:0] b);
      @(negedge clk);
      dataIn[idx]  = b;
      validIn[idx] = 1'b1;
      checkOutput($sformatf("dut%0d readyBeforeAccept", idx), 32'(readyOut[idx]), 32'd1);
   endtask

   task automatic idleCheck(input int idx, input int cycles);
      int errs;
      errs = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (txdOut[idx] !== 1'b1 || readyOut[idx] !== 1'b1 ||
             busyOut[idx] !== 1'b0 || doneOut[idx] !== 1'b0) errs++;
      end
      checkOutput($sformatf("dut%0d idleLine", idx), 32'(errs), 32'd0);
   endtask

   // Follows one frame from its accept edge; optionally disturbs the inputs
   // mid-frame, chains a held-valid next byte, or aborts the frame with reset.
   task automatic monitorFrame(input int idx, input logic [7:0] b, input logic [7:0] nextByte,
                               input bit keepValid, input int disturbAt, input int abortAt);
      logic [10:0] expBits;
      int          baud;
      int          total;
      int          badBits [11];
      int          handshakeErrs;
      int          doneCount;
      int          doneAt;
      int          k;
      int          prefixBad;
      expBits       = frameBits(b, oddOf[idx]);
      baud          = baudOf[idx];
      total         = 11 * baud;
      handshakeErrs = 0;
      doneCount     = 0;
      doneAt        = -1;
      foreach (badBits[i]) badBits[i] = 0;

      @(posedge clk);
      for (int n = 1; n <= total; n++) begin
         @(negedge clk);
         k = (n - 1) / baud;
         if (txdOut[idx] !== expBits[k]) badBits[k]++;
         if (readyOut[idx] !== 1'b0 || busyOut[idx] !== 1'b1) handshakeErrs++;
         if (doneOut[idx] === 1'b1) begin
            doneCount++;
            if (doneAt < 0) doneAt = n;
         end
         if (n == 1) begin
            if (keepValid) dataIn[idx] = nextByte;
            else validIn[idx] = 1'b0;
         end
         if (disturbAt > 0 && n == disturbAt) begin
            dataIn[idx]  = 8'($urandom);
            validIn[idx] = 1'b1;
         end
         if (disturbAt > 0 && n == disturbAt + 1) validIn[idx] = 1'b0;
         if (abortAt > 0 && n == abortAt) begin
            prefixBad = 0;
            for (int j = 0; j <= k; j++) prefixBad += badBits[j];
            checkOutput($sformatf("dut%0d abortPrefixBits", idx), 32'(prefixBad), 32'd0);
            rstN = 1'b0;
            #1;
            checkOutput($sformatf("dut%0d abortTxdHigh", idx), 32'(txdOut[idx]), 32'd1);
            checkOutput($sformatf("dut%0d abortBusyLow", idx), 32'(busyOut[idx]), 32'd0);
            checkOutput($sformatf("dut%0d abortReady", idx), 32'(readyOut[idx]), 32'd1);
            repeat (3) begin
               @(negedge clk);
               if (doneOut[idx] === 1'b1) doneCount++;
            end
            checkOutput($sformatf("dut%0d abortNoDone", idx), 32'(doneCount), 32'd0);
            rstN = 1'b1;
            return;
         end
      end

      for (int j = 0; j < 11; j++)
         checkOutput($sformatf("dut%0d byte%02h bit%0d", idx, b, j), 32'(badBits[j]), 32'd0);
      checkOutput($sformatf("dut%0d doneCycle", idx), 32'(doneAt), 32'(total));
      checkOutput($sformatf("dut%0d doneCount", idx), 32'(doneCount), 32'd1);
      checkOutput($sformatf("dut%0d handshake", idx), 32'(handshakeErrs), 32'd0);

      @(negedge clk);
      checkOutput($sformatf("dut%0d gapTxd", idx), 32'(txdOut[idx]), 32'd1);
      checkOutput($sformatf("dut%0d gapReady", idx), 32'(readyOut[idx]), 32'd1);
      checkOutput($sformatf("dut%0d gapBusy", idx), 32'(busyOut[idx]), 32'd0);
      checkOutput($sformatf("dut%0d gapDone", idx), 32'(doneOut[idx]), 32'd0);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] b2;
      int         idx;

      rstN = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         dataIn[i]  = 8'h00;
         validIn[i] = 1'b0;
      end
      repeat (10) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checkOutput($sformatf("dut%0d resetTxd", i), 32'(txdOut[i]), 32'd1);
         checkOutput($sformatf("dut%0d resetReady", i), 32'(readyOut[i]), 32'd1);
         checkOutput($sformatf("dut%0d resetBusy", i), 32'(busyOut[i]), 32'd0);
         checkOutput($sformatf("dut%0d resetDone", i), 32'(doneOut[i]), 32'd0);
      end
      rstN = 1'b1;
      idleCheck(0, 20);
      idleCheck(1, 20);
      idleCheck(2, 20);

      $display("[TB] full-rate frame 0x55");
      applyStimulus(0, 8'h55);
      monitorFrame(0, 8'h55, 8'h00, 1'b0, 0, 0);

      $display("[TB] parity corner bytes");
      applyStimulus(1, 8'h00);
      monitorFrame(1, 8'h00, 8'h00, 1'b0, 0, 0);
      applyStimulus(2, 8'h00);
      monitorFrame(2, 8'h00, 8'h00, 1'b0, 0, 0);
      applyStimulus(1, 8'hA7);
      monitorFrame(1, 8'hA7, 8'h00, 1'b0, 0, 0);

      $display("[TB] random bytes");
      for (int i = 0; i < 8; i++) begin
         b   = 8'($urandom);
         idx = 1 + (i % 2);
         applyStimulus(idx, b);
         monitorFrame(idx, b, 8'h00, 1'b0, 0, 0);
      end

      $display("[TB] back-to-back frames");
      applyStimulus(1, 8'h3C);
      monitorFrame(1, 8'h3C, 8'hC3, 1'b1, 0, 0);
      monitorFrame(1, 8'hC3, 8'h00, 1'b0, 0, 0);
      b  = 8'($urandom);
      b2 = 8'($urandom);
      applyStimulus(2, b);
      monitorFrame(2, b, b2, 1'b1, 0, 0);
      monitorFrame(2, b2, 8'h00, 1'b0, 0, 0);

      $display("[TB] data stability while busy");
      b = 8'($urandom);
      applyStimulus(1, b);
      monitorFrame(1, b, 8'h00, 1'b0, 4 * FAST + 3, 0);
      idleCheck(1, 3 * FAST);

      $display("[TB] reset mid-frame");
      applyStimulus(1, 8'h5A);
      monitorFrame(1, 8'h5A, 8'h00, 1'b0, 0, 5 * FAST + FAST / 2);
      idleCheck(1, 5);
      applyStimulus(1, 8'hFF);
      monitorFrame(1, 8'hFF, 8'h00, 1'b0, 0, 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the FPGA-to-host direction of the 115200-baud link. It accepts one byte per valid/ready handshake and serializes it as an 11-bit frame: start bit, 8 data bits LSB first, parity bit, stop bit. Frame format, bit period and parity rule are identical to the receive path, so a loopback of `txd` into the receiver reproduces the byte with a valid flag.

## Interface
- `BAUD_CNT`, default 868: `sys_clk` cycles per bit (100 MHz / 115200).
- `PARITY_TYPE`, default 1: 1 = odd parity, 0 = even parity.
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on accept.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `txd`  out  1  serial line; idle high; registered output.
- `tx_busy`  out  1  a frame is in progress.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- **Accept:** a byte is accepted on a rising edge where `tx_valid && tx_ready`. On accept, `tx_data` is latched into a shift register and parity is computed from the latched byte.
  - Even parity: `^data`.
  - Odd parity: `~^data`.
  - Later changes to `tx_data` do not affect the frame in flight.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `txd` = 1, `tx_ready` = 1, `tx_busy` = 0. On accept, go to START.
  - START: `txd` = 0 for `BAUD_CNT` cycles, then go to DATA.
  - DATA: `txd` = current LSB of the shift register. Shift right every `BAUD_CNT` cycles. A 3-bit bit counter advances 0..7. After bit 7 completes, go to PARITY.
  - PARITY: `txd` = the parity bit for `BAUD_CNT` cycles, then go to STOP.
  - STOP: `txd` = 1 for `BAUD_CNT` cycles.
    - `tx_done` = 1 in the cycle where the baud counter = `BAUD_CNT`-1.
    - The next state is IDLE.
- **Baud counter:** runs 0..`BAUD_CNT`-1 whenever the state is not IDLE. It wraps to 0 at `BAUD_CNT`-1, and that wrap is the bit-advance event. The counter is forced to 0 in IDLE. Width is `$clog2(BAUD_CNT)`, which is 10 bits for 868.
- **`tx_ready`** is 1 only in IDLE. There is no buffering beyond the single frame register.
- **Back-to-back frames:** if `tx_valid` is held high, the next byte is accepted in the first IDLE cycle after `tx_done`. Line idle between frames is exactly 1 cycle beyond the stop bit.
- **`tx_busy`** is 1 in START, DATA, PARITY and STOP.
- **Reset:** asynchronous.
  - Outputs during and after reset: `txd` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0.
  - Internal state: FSM = IDLE, counters = 0, shift register = 0.
  - Reset mid-frame abandons the frame. `txd` returns high immediately and no `tx_done` is issued.

## Timing
- Let cycle A be the accept edge.
- The frame occupies cycles A+1 .. A+11·`BAUD_CNT`, which is 9548 cycles at default.
- `txd` falls at A+1. This is registered, so there is one cycle of latency from accept to start bit.
- Bit k (start = 0, data = 1..8, parity = 9, stop = 10) is driven during cycles A+1+k·`BAUD_CNT` .. A+(k+1)·`BAUD_CNT`.
- `tx_done` is high in cycle A+11·`BAUD_CNT`.
- `tx_ready` is 1 again in cycle A+11·`BAUD_CNT`+1. The earliest next accept is at that edge.
- `tx_valid` asserted while busy is ignored and has no side effects. The byte is taken when `tx_ready` returns, if `tx_valid` is still high.
- `txd` is glitch-free because it is driven directly from a flop.

## Test plan
- **Reset:** hold `sys_rst_n` = 0 for 10 cycles, release -> `txd` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0; the line stays idle with no valid.
- **Single frame, `PARITY_TYPE` = 1:** send 0x55 -> `txd` sequence 0,1,0,1,0,1,0,1,0,1,1; each bit exactly 868 cycles; `tx_done` at A+9548; `tx_ready` at A+9549.
- **Parity:**
  - 0x00 with odd parity -> parity bit 1.
  - 0x00 with `PARITY_TYPE` = 0 -> parity bit 0.
  - 0xA7 with odd parity -> parity bit 0 (5 ones).
- **Back-to-back:** `tx_valid` held high, bytes 0x3C then 0xC3 -> second start bit begins exactly 1 cycle after the first stop bit ends. Feeding `txd` into `uart_rx` yields `valid_flag` pulses with `valid_data` 0x3C then 0xC3.
- **Data stability:** change `tx_data` and pulse `tx_valid` mid-frame -> the transmitted frame is unchanged, no extra accept occurs, and `tx_ready` stays 0.
- **Reset mid-frame:** assert reset in DATA bit 4 -> `txd` = 1 asynchronously and no `tx_done`. After release, a new frame with 0xFF transmits correctly: bits 0,1×8,1 (odd parity),1.
